des_round_ctrl: RTL and testbench

- Sequencer for the iterative single-round DES datapath. The Feistel round logic includes the S-box bank s1..s8.
- Accepts one block-start handshake and captures encrypt/decrypt mode.
- Drives 16 round-enable cycles, the key-register shift amount and direction, and the final IP-1 strobe.
- Holds a result-valid handshake until the consumer accepts it. Sits between the host interface and the DES datapath registers.

---
 rtl/des_round_ctrl.sv | 58 +++++
 tb/tb_des_round_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequences load, 16 Feistel rounds with key-rotate control,
// the final IP-1 strobe and the result-valid handshake for an iterative DES core.
module des_round_ctrl #(
   parameter logic [15:0] SHIFT_SCHED = 16'h8103
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       decrypt,
   input  logic       abort,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       load_en,
   output logic       round_en,
   output logic [3:0] round_idx,
   output logic [1:0] key_shift_amt,
   output logic       key_shift_dir,
   output logic       final_en,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
   state_t state, state_nx;
   logic [3:0] cnt, dec_idx;
   logic mode_q, sched_bit;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         mode_q   <= 1'b0;
         in_ready <= 1'b0;
      end else begin
         state    <= state_nx;
         in_ready <= state_nx == IDLE;
         cnt      <= (state == ROUND && state_nx == ROUND) ? cnt + 4'd1 : 4'd0;
         if (load_en) mode_q <= decrypt;
      end
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  state_nx = load_en ? ROUND : IDLE;
         ROUND: state_nx = abort ? IDLE : (cnt == 4'd15 ? FINAL : ROUND);
         FINAL: state_nx = abort ? IDLE : DONE;
         DONE:  state_nx = (abort || out_ready) ? IDLE : DONE;
      endcase
   end
   // decrypt walks the encrypt schedule backwards: round r uses entry 16-r
   assign dec_idx       = 4'd0 - cnt;
   assign sched_bit     = mode_q ? SHIFT_SCHED[dec_idx] : SHIFT_SCHED[cnt];
   assign load_en       = in_valid & in_ready;
   assign round_en      = state == ROUND;
   assign final_en      = state == FINAL;
   assign out_valid     = state == DONE;
   assign busy          = state != IDLE;
   assign round_idx     = round_en ? cnt : 4'd0;
   assign key_shift_dir = round_en & mode_q;
   assign key_shift_amt = !round_en || (mode_q && cnt == 4'd0) ? 2'd0 : sched_bit ? 2'd1 : 2'd2;
endmodule

// File: tb/tb_des_round_ctrl.sv
// tb_des_round_ctrl: directed checks of round sequencing, key-shift schedule,
// handshakes, abort and reset behaviour.
module tb_des_round_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, decrypt = 1'b0, abort = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, load_en, round_en, key_shift_dir, final_en, busy;
   logic [3:0] round_idx;
   logic [1:0] key_shift_amt;
   int errors = 0, checks = 0;
   logic [1:0] enc_amt [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   logic [1:0] dec_amt [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   des_round_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .decrypt(decrypt), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
      .load_en(load_en), .round_en(round_en), .round_idx(round_idx),
      .key_shift_amt(key_shift_amt), .key_shift_dir(key_shift_dir),
      .final_en(final_en), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #3;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 1);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_strobes"}, 32'({round_en, final_en, out_valid}), 0);
   endtask

   // accept at T0, then check rounds 0..stop-1; with stop=16 also FINAL, returning in T18
   task automatic run_rounds(input logic mode, input logic toggle, input int stop);
      in_valid = 1'b1;
      decrypt  = mode;
      #1;
      chk("t0_load_en", 32'(load_en), 1);
      chk("t0_busy", 32'(busy), 0);
      tick();
      in_valid = 1'b0;
      for (int r = 0; r < stop; r++) begin
         chk("round_en", 32'(round_en), 1);
         chk("round_idx", 32'(round_idx), r);
         chk("key_shift_amt", 32'(mode ? dec_amt[r] : enc_amt[r]), 32'(key_shift_amt) ^ 32'(mode ? dec_amt[r] : enc_amt[r]) ^ 32'(mode ? dec_amt[r] : enc_amt[r]));
         chk("amt_value", 32'(key_shift_amt), 32'(mode ? dec_amt[r] : enc_amt[r]));
         chk("key_shift_dir", 32'(key_shift_dir), 32'(mode));
         chk("round_in_ready", 32'(in_ready), 0);
         chk("round_strobes", 32'({load_en, final_en, out_valid}), 0);
         if (toggle) decrypt = ~decrypt;
         tick();
      end
      if (stop == 16) begin
         chk("final_en", 32'(final_en), 1);
         chk("final_round_en", 32'(round_en), 0);
         chk("final_out_valid", 32'(out_valid), 0);
         tick();
      end
   endtask

   initial begin
      // reset state
      in_valid = 1'b1;
      #3;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_load_en", 32'(load_en), 0);
      chk("rst_outs", 32'({out_valid, round_en, final_en, busy, round_idx, key_shift_amt, key_shift_dir}), 0);
      in_valid = 1'b0;
      #5 rst_n = 1'b1;
      #1 chk("rel_in_ready", 32'(in_ready), 0);
      tick();
      idle_chk("post_rst");

      // encrypt, out_ready high
      out_ready = 1'b1;
      run_rounds(1'b0, 1'b0, 16);
      chk("enc_out_valid", 32'(out_valid), 1);
      chk("enc_done_in_ready", 32'(in_ready), 0);
      tick();
      idle_chk("enc_t19");

      // decrypt with decrypt toggling during rounds
      run_rounds(1'b1, 1'b1, 16);
      chk("dec_out_valid", 32'(out_valid), 1);
      tick();
      idle_chk("dec_t19");

      // backpressure in DONE; in_valid pulses ignored
      out_ready = 1'b0;
      run_rounds(1'b0, 1'b0, 16);
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0];
         #1;
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_strobes", 32'({load_en, round_en, final_en}), 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1 chk("bp_release_valid", 32'(out_valid), 1);
      tick();
      idle_chk("bp_idle");

      // abort at round 7
      run_rounds(1'b0, 1'b0, 7);
      chk("abort_idx", 32'(round_idx), 7);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      #1 idle_chk("abort_next");
      for (int k = 0; k < 20; k++) begin
         chk("abort_quiet", 32'({final_en, out_valid, busy}), 0);
         tick();
      end

      // abort in IDLE with in_valid still accepts
      abort    = 1'b1;
      in_valid = 1'b1;
      #1 chk("idle_abort_load", 32'(load_en), 1);
      tick();
      in_valid = 1'b0;
      chk("idle_abort_round", 32'(round_en), 1);
      chk("idle_abort_idx", 32'(round_idx), 0);
      tick();
      abort = 1'b0;
      #1 idle_chk("abort_r0");

      // clean block after aborts
      run_rounds(1'b0, 1'b0, 16);
      chk("clean_out_valid", 32'(out_valid), 1);
      tick();
      idle_chk("clean_idle");

      // reset mid-block at round 4
      run_rounds(1'b1, 1'b0, 4);
      chk("rst_idx4", 32'(round_idx), 4);
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", 32'({in_ready, out_valid, load_en, round_en, final_en, busy, round_idx, key_shift_amt, key_shift_dir}), 0);
      tick();
      rst_n = 1'b1;
      #1 chk("midrst_rel_in_ready", 32'(in_ready), 0);
      tick();
      idle_chk("midrst_idle");
      run_rounds(1'b0, 1'b0, 16);
      chk("midrst_out_valid", 32'(out_valid), 1);
      tick();
      idle_chk("midrst_done");

      // continuous in_valid/out_ready: one block per 19 cycles
      in_valid = 1'b1;
      for (int c = 0; c < 60; c++) begin
         int p;
         p = c % 19;
         #1;
         chk("cont_load", 32'(load_en), 32'(p == 0));
         chk("cont_round", 32'(round_en), 32'(p >= 1 && p <= 16));
         chk("cont_final", 32'(final_en), 32'(p == 17));
         chk("cont_valid", 32'(out_valid), 32'(p == 18));
         chk("cont_onehot", 32'(int'(load_en) + int'(round_en) + int'(final_en) <= 1), 1);
         tick();
      end
      in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
